// File: rtl/d_latch.sv
// Gated D-latch with complementary outputs, built on a clocked register so timing
// analysis only ever sees flip-flops. Transparent while en=1, holding while en=0.
module d_latch #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             q_changed
);

  logic [WIDTH-1:0] stored_p0;
  logic             chg_p0;

  // Stage p0: stored value and its change flag, captured on the rising edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stored_p0 <= RESET_VALUE;
      chg_p0    <= 1'b0;
    end else begin
      chg_p0 <= en && (d != stored_p0);
      if (en) begin
        stored_p0 <= d;
      end
    end
  end

  // Output path: the gate selects d directly so transparency has no clock latency,
  // and a closed gate never lets d (even if unknown) reach q.
  always_comb begin
    q = stored_p0;
    if (!reset) begin
      q = RESET_VALUE;
    end else if (en) begin
      q = d;
    end
  end

  assign qb        = ~q;
  assign q_changed = chg_p0;

endmodule

// File: tb/tb_d_latch.sv
// Bench for d_latch: a 1-bit instance (RESET_VALUE=0) and an 8-bit instance
// (RESET_VALUE=A5) share reset/en; a scoreboard queue feeds an independent monitor.
module tb_d_latch;

  logic       clk;
  logic       reset;
  logic       en;
  logic [0:0] d1;
  logic [7:0] d8;
  logic [0:0] q1, qb1;
  logic [7:0] q8, qb8;
  logic       qc1, qc8;

  int n_cmp;
  int n_bad;

  typedef struct packed {
    logic [0:0] q1;
    logic [0:0] qb1;
    logic       qc1;
    logic [7:0] q8;
    logic [7:0] qb8;
    logic       qc8;
  } exp_t;

  exp_t sb[$];
  event sample_ev;

  // Reference state: the value last captured with the gate open, and the change flag
  logic [0:0] m_st1;
  logic [7:0] m_st8;
  logic       m_qc1, m_qc8;

  d_latch #(.WIDTH(1), .RESET_VALUE(1'b0)) dut1 (
    .clk(clk), .reset(reset), .en(en), .d(d1), .q(q1), .qb(qb1), .q_changed(qc1)
  );

  d_latch #(.WIDTH(8), .RESET_VALUE(8'hA5)) dut8 (
    .clk(clk), .reset(reset), .en(en), .d(d8), .q(q8), .qb(qb8), .q_changed(qc8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per presented sample and compares all outputs
  initial begin
    exp_t x;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
      end else begin
        x = sb.pop_front();
        chk("q1",  {7'b0, q1},  {7'b0, x.q1});
        chk("qb1", {7'b0, qb1}, {7'b0, x.qb1});
        chk("qc1", {7'b0, qc1}, {7'b0, x.qc1});
        chk("q8",  q8,  x.q8);
        chk("qb8", qb8, x.qb8);
        chk("qc8", {7'b0, qc8}, {7'b0, x.qc8});
      end
    end
  end

  // Drive one set of inputs between clock edges, publish the expectation,
  // then advance past the next rising edge and update the reference.
  task automatic step(input logic r, input logic e, input logic [0:0] v1, input logic [7:0] v8);
    exp_t x;
    reset = r;
    en    = e;
    d1    = v1;
    d8    = v8;
    if (!r) begin
      m_st1 = 1'b0;
      m_st8 = 8'hA5;
      m_qc1 = 1'b0;
      m_qc8 = 1'b0;
    end
    x.q1  = !r ? 1'b0  : (e ? v1 : m_st1);
    x.q8  = !r ? 8'hA5 : (e ? v8 : m_st8);
    x.qb1 = ~x.q1;
    x.qb8 = ~x.q8;
    x.qc1 = m_qc1;
    x.qc8 = m_qc8;
    sb.push_back(x);
    #1 -> sample_ev;
    @(posedge clk);
    if (r) begin
      m_qc1 = e && (v1 != m_st1);
      m_qc8 = e && (v8 != m_st8);
      if (e) begin
        m_st1 = v1;
        m_st8 = v8;
      end
    end
    #2;
  endtask

  initial begin
    logic [7:0] xv;
    logic       r, e;
    logic [0:0] v1;
    logic [7:0] v8;
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    en    = 1'b0;
    d1    = 1'b0;
    d8    = 8'h00;
    m_st1 = 1'b0;
    m_st8 = 8'hA5;
    m_qc1 = 1'b0;
    m_qc8 = 1'b0;
    xv    = 'x;
    #2;

    // Reset with gate open: outputs pinned to reset value
    step(1'b0, 1'b1, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 1'b1, 8'hFF);

    // Asynchronous release with gate open, then transparent toggling
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    step(1'b1, 1'b1, 1'b1, 8'h3C);

    // Gate closes with q=1 / 3C stored; d changes are ignored
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'hC3);
    step(1'b1, 1'b0, 1'b0, 8'h11);
    step(1'b1, 1'b0, xv[0:0], xv);

    // Mid-cycle reset while holding, release with gate closed
    step(1'b0, 1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b1, 8'h77);
    step(1'b1, 1'b0, 1'b0, 8'h77);

    // Gate open with d equal to stored value for five edges: no change pulse
    repeat (5) step(1'b1, 1'b1, 1'b0, 8'hA5);
    step(1'b1, 1'b1, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);

    // Randomized traffic
    repeat (400) begin
      r  = ($urandom_range(0, 19) != 0);
      e  = 1'($urandom_range(0, 1));
      v1 = 1'($urandom);
      v8 = ($urandom_range(0, 3) == 0) ? m_st8 : 8'($urandom);
      if (!e && $urandom_range(0, 3) == 0) begin
        v1 = xv[0:0];
        v8 = xv;
      end
      step(r, e, v1, v8);
    end

    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
